// File: rtl/ps2_key_decoder_pkg.sv
// Shared scan codes (set 2), decoder state encoding and the frame parity helper
// for the PS/2 key decoder.
package ps2_key_decoder_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_W     = 8'h1D;
  localparam logic [7:0] PS2_S     = 8'h1B;
  localparam logic [7:0] PS2_UP    = 8'h75;
  localparam logic [7:0] PS2_DOWN  = 8'h72;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXTBRK
  } dec_state_t;

  // Odd parity over the data byte plus its parity bit.
  function automatic logic parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronisers, ps2_clk glitch filter, 11-bit frame
// capture and checks. Define PS2_TIMEOUT_EN to discard stalled partial frames.
module ps2_rx
  import ps2_key_decoder_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);

  if (FILTER_LEN < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("ps2_rx: FILTER_LEN must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          filt;
  logic [FW-1:0] fcnt;
  logic [3:0]    bcnt;
  logic [7:0]    shreg;
  logic          par;
  logic          accept;
  logic          fall;
  logic          din;

  // A level change is taken on the FILTER_LEN-th consecutive differing sample.
  assign accept = (clk_sync[1] != filt) && (fcnt == FW'(FILTER_LEN - 1));
  assign fall   = accept && !clk_sync[1];
  assign din    = dat_sync[1];

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync   <= 2'b11;
      dat_sync   <= 2'b11;
      filt       <= 1'b1;
      fcnt       <= '0;
      bcnt       <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      data_byte  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PS2_TIMEOUT_EN
      tcnt       <= '0;
`endif
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk};
      dat_sync   <= {dat_sync[0], ps2_data};
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;

      if (clk_sync[1] == filt) begin
        fcnt <= '0;
      end else if (accept) begin
        filt <= clk_sync[1];
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end

      if (fall) begin
        case (bcnt)
          4'd0: begin
            if (!din) bcnt <= 4'd1;
            else      frame_err <= 1'b1;
          end
          4'd9: begin
            par  <= din;
            bcnt <= 4'd10;
          end
          4'd10: begin
            bcnt <= '0;
            if (din && parity_ok(shreg, par)) begin
              data_byte  <= shreg;
              byte_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: begin
            shreg <= {din, shreg[7:1]};
            bcnt  <= bcnt + 1'b1;
          end
        endcase
      end

`ifdef PS2_TIMEOUT_EN
      if (accept)             tcnt <= '0;
      else if (bcnt != 4'd0)  tcnt <= tcnt + 1'b1;
      if (bcnt != 4'd0 && tcnt == TW'(TIMEOUT_CYCLES)) begin
        bcnt      <= '0;
        tcnt      <= '0;
        frame_err <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard to paddle-key decoder: W/S drive keys_left, ArrowUp/ArrowDown drive
// keys_right. Define PS2_TIMEOUT_EN to enable the receiver's partial-frame timeout.
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [1:0] keys_left,
  output logic [1:0] keys_right,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  dec_state_t state;

  ps2_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .data_byte (rx_byte),
    .byte_valid(rx_valid),
    .frame_err (frame_err)
  );

  // A receive error drops any pending E0/F0 prefix but keeps held keys.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      keys_left  <= 2'b00;
      keys_right <= 2'b00;
    end else if (frame_err) begin
      state <= S_IDLE;
    end else if (rx_valid) begin
      state <= S_IDLE;
      case (state)
        S_IDLE: begin
          case (rx_byte)
            PS2_EXT:   state <= S_EXT;
            PS2_BREAK: state <= S_BRK;
            PS2_W:     keys_left[1] <= 1'b1;
            PS2_S:     keys_left[0] <= 1'b1;
            default:   ;
          endcase
        end
        S_EXT: begin
          case (rx_byte)
            PS2_BREAK: state <= S_EXTBRK;
            PS2_UP:    keys_right[1] <= 1'b1;
            PS2_DOWN:  keys_right[0] <= 1'b1;
            default:   ;
          endcase
        end
        S_BRK: begin
          if (rx_byte == PS2_W) keys_left[1] <= 1'b0;
          if (rx_byte == PS2_S) keys_left[0] <= 1'b0;
        end
        S_EXTBRK: begin
          if (rx_byte == PS2_UP)   keys_right[1] <= 1'b0;
          if (rx_byte == PS2_DOWN) keys_right[0] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
